packed_frame_reader: RTL



---
 rtl/packed_frame_reader.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/packed_frame_reader.sv
// Streams one bit-packed edge frame (DEPTH bytes) from the buffer's synchronous
// read port to the UART TX over valid/ready. Define FRAME_CHECKSUM_EN to append an XOR checksum byte.
module packed_frame_reader #(
    parameter int DEPTH  = 5100,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              rEn,
    output logic [ADDR_W-1:0] rAddr,
    input  logic [7:0]        rData,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic              busy,
    output logic              done
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LATCH,
        S_SEND,
`ifdef FRAME_CHECKSUM_EN
        S_CKSUM,
`endif
        S_DONE
    } state_t;

    state_t            r_state;
    logic              r_ren;
    logic [ADDR_W-1:0] r_addr;
    logic [7:0]        r_data;
    logic              r_valid;
    logic              r_busy;
    logic              r_done;
`ifdef FRAME_CHECKSUM_EN
    logic [7:0]        r_xor;
    logic [7:0]        w_xor_nxt;
`endif

    state_t            w_state_nxt;
    logic              w_ren_nxt;
    logic [ADDR_W-1:0] w_addr_nxt;
    logic [7:0]        w_data_nxt;
    logic              w_valid_nxt;
    logic              w_busy_nxt;
    logic              w_done_nxt;
    logic              w_xfer;

    assign w_xfer = r_valid && tx_ready;

    always_comb begin
        w_state_nxt = r_state;
        w_ren_nxt   = 1'b0;
        w_addr_nxt  = r_addr;
        w_data_nxt  = r_data;
        w_valid_nxt = r_valid;
        w_busy_nxt  = r_busy;
        w_done_nxt  = 1'b0;
`ifdef FRAME_CHECKSUM_EN
        w_xor_nxt   = r_xor;
`endif
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    // rEn is registered, so it is raised on entry to FETCH
                    w_state_nxt = S_FETCH;
                    w_ren_nxt   = 1'b1;
                    w_addr_nxt  = '0;
                    w_busy_nxt  = 1'b1;
`ifdef FRAME_CHECKSUM_EN
                    w_xor_nxt   = '0;
`endif
                end
            end
            S_FETCH: begin
                w_state_nxt = S_LATCH;
            end
            S_LATCH: begin
                w_data_nxt  = rData;
                w_valid_nxt = 1'b1;
                w_state_nxt = S_SEND;
            end
            S_SEND: begin
                if (w_xfer) begin
                    w_valid_nxt = 1'b0;
`ifdef FRAME_CHECKSUM_EN
                    w_xor_nxt   = r_xor ^ r_data;
`endif
                    if (r_addr == LAST_ADDR) begin
`ifdef FRAME_CHECKSUM_EN
                        w_data_nxt  = r_xor ^ r_data;
                        w_valid_nxt = 1'b1;
                        w_state_nxt = S_CKSUM;
`else
                        w_done_nxt  = 1'b1;
                        w_state_nxt = S_DONE;
`endif
                    end else begin
                        w_addr_nxt  = r_addr + 1'b1;
                        w_ren_nxt   = 1'b1;
                        w_state_nxt = S_FETCH;
                    end
                end
            end
`ifdef FRAME_CHECKSUM_EN
            S_CKSUM: begin
                if (w_xfer) begin
                    w_valid_nxt = 1'b0;
                    w_done_nxt  = 1'b1;
                    w_state_nxt = S_DONE;
                end
            end
`endif
            S_DONE: begin
                w_addr_nxt  = '0;
                w_busy_nxt  = 1'b0;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_ren   <= 1'b0;
            r_addr  <= '0;
            r_data  <= '0;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
`ifdef FRAME_CHECKSUM_EN
            r_xor   <= '0;
`endif
        end else begin
            r_state <= w_state_nxt;
            r_ren   <= w_ren_nxt;
            r_addr  <= w_addr_nxt;
            r_data  <= w_data_nxt;
            r_valid <= w_valid_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
`ifdef FRAME_CHECKSUM_EN
            r_xor   <= w_xor_nxt;
`endif
        end
    end

    assign rEn      = r_ren;
    assign rAddr    = r_addr;
    assign tx_data  = r_data;
    assign tx_valid = r_valid;
    assign busy     = r_busy;
    assign done     = r_done;

endmodule
